// File: rtl/crono_cuenta_regresiva.sv
// Countdown timer core: hh:mm:ss packed-BCD count decremented on a 1 Hz tick,
// with every count change published as a three-cycle byte/select write burst.
module crono_cuenta_regresiva (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic       ack,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       ring,
  output logic       load_err,
  output logic [7:0] dato,
  output logic [2:0] wr_sel
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_hh;
  logic [7:0] r_mm;
  logic [7:0] r_ss;
  logic [7:0] w_hh_next;
  logic [7:0] w_mm_next;
  logic [7:0] w_ss_next;

  logic       r_load_err;
  logic       w_load_err_next;
  logic       w_change;

  logic       r_pend;
  logic [2:0] r_wr_sel;
  logic [7:0] r_dato;

  logic       w_set_valid;
  logic       w_load_ok_state;

  logic [7:0] w_ss_dec;
  logic [7:0] w_mm_dec;
  logic [7:0] w_hh_dec;
  logic       w_ss_borrow;
  logic       w_mm_borrow;
  logic [7:0] w_mm_after;
  logic [7:0] w_hh_after;
  logic       w_dec_zero;

  // Every nibble must be a decimal digit before the range limits are meaningful.
  always_comb begin
    w_set_valid = (set_hh[3:0] <= 4'd9) && (set_hh[7:4] <= 4'd9) &&
                  (set_mm[3:0] <= 4'd9) && (set_mm[7:4] <= 4'd9) &&
                  (set_ss[3:0] <= 4'd9) && (set_ss[7:4] <= 4'd9) &&
                  (set_ss <= 8'h59) && (set_mm <= 8'h59) && (set_hh <= 8'h23);
  end

  assign w_load_ok_state = (r_state != S_RUN);

  // Seconds: 00 wraps to 59 and borrows from minutes.
  always_comb begin
    w_ss_borrow = 1'b0;
    w_ss_dec    = r_ss;
    if (r_ss == 8'h00) begin
      w_ss_dec    = 8'h59;
      w_ss_borrow = 1'b1;
    end else if (r_ss[3:0] == 4'd0) begin
      w_ss_dec = {r_ss[7:4] - 4'd1, 4'd9};
    end else begin
      w_ss_dec = {r_ss[7:4], r_ss[3:0] - 4'd1};
    end
  end

  always_comb begin
    w_mm_borrow = 1'b0;
    w_mm_dec    = r_mm;
    if (r_mm == 8'h00) begin
      w_mm_dec    = 8'h59;
      w_mm_borrow = 1'b1;
    end else if (r_mm[3:0] == 4'd0) begin
      w_mm_dec = {r_mm[7:4] - 4'd1, 4'd9};
    end else begin
      w_mm_dec = {r_mm[7:4], r_mm[3:0] - 4'd1};
    end
  end

  // Hours never wrap: a borrow out of 00 hours cannot happen because 00:00:00 is terminal.
  always_comb begin
    w_hh_dec = r_hh;
    if (r_hh[3:0] == 4'd0) begin
      w_hh_dec = {r_hh[7:4] - 4'd1, 4'd9};
    end else begin
      w_hh_dec = {r_hh[7:4], r_hh[3:0] - 4'd1};
    end
  end

  always_comb begin
    w_mm_after = w_ss_borrow ? w_mm_dec : r_mm;
    w_hh_after = (w_ss_borrow && w_mm_borrow) ? w_hh_dec : r_hh;
    w_dec_zero = (w_ss_dec == 8'h00) && (w_mm_after == 8'h00) && (w_hh_after == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hh       <= 8'h00;
      r_mm       <= 8'h00;
      r_ss       <= 8'h00;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hh       <= w_hh_next;
      r_mm       <= w_mm_next;
      r_ss       <= w_ss_next;
      r_load_err <= w_load_err_next;
    end
  end

  // Priority: load > stop > start > tick; ack only matters in DONE.
  always_comb begin
    w_state_next    = r_state;
    w_hh_next       = r_hh;
    w_mm_next       = r_mm;
    w_ss_next       = r_ss;
    w_load_err_next = 1'b0;
    w_change        = 1'b0;

    if (load && w_load_ok_state) begin
      if (w_set_valid) begin
        w_hh_next    = set_hh;
        w_mm_next    = set_mm;
        w_ss_next    = set_ss;
        w_state_next = S_IDLE;
        w_change     = 1'b1;
      end else begin
        w_load_err_next = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE, S_PAUSE: begin
          if (start && !((r_hh == 8'h00) && (r_mm == 8'h00) && (r_ss == 8'h00))) begin
            w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            w_state_next = S_PAUSE;
          end else if (tick_1hz) begin
            w_ss_next = w_ss_dec;
            w_mm_next = w_mm_after;
            w_hh_next = w_hh_after;
            w_change  = 1'b1;
            if (w_dec_zero) begin
              w_state_next = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (ack) begin
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Burst: a change sets r_pend, which launches cycle 1 on the following edge
  // and overrides any burst already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend   <= 1'b0;
      r_wr_sel <= 3'b000;
      r_dato   <= 8'h00;
    end else begin
      r_pend <= w_change;
      if (r_pend) begin
        r_wr_sel <= 3'b001;
        r_dato   <= r_ss;
      end else begin
        case (r_wr_sel)
          3'b001: begin
            r_wr_sel <= 3'b010;
            r_dato   <= r_mm;
          end
          3'b010: begin
            r_wr_sel <= 3'b100;
            r_dato   <= r_hh;
          end
          default: r_wr_sel <= 3'b000;
        endcase
      end
    end
  end

  assign hh       = r_hh;
  assign mm       = r_mm;
  assign ss       = r_ss;
  assign running  = (r_state == S_RUN);
  assign ring     = (r_state == S_DONE);
  assign load_err = r_load_err;
  assign dato     = r_dato;
  assign wr_sel   = r_wr_sel;

endmodule
